// File: rtl/nand_gate.sv
// nand_gate: parameterised bitwise two-input NAND with registered copy and saturating activity counter
//   y       out [WIDTH]  combinational ~(a & b); no clock, reset or enable dependence
//   a, b    in  [WIDTH]  operands
//   clk     in           rising-edge clock for y_q and act_cnt
//   rst     in           synchronous active-high reset: y_q <= all ones, act_cnt <= 0
//   en      in           capture enable for y_q
//   y_q     out [WIDTH]  y sampled on enabled edges
//   act_cnt out [CNT_W]  count of captures that changed y_q, saturating at all ones
// y is declared first so a positional (y, a, b) hookup yields a plain NAND cell.
module nand_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] y_q,
    output logic [CNT_W-1:0] act_cnt
);
    // Continuous assign keeps standard X/Z semantics: a 0 on either side forces 1.
    assign y = ~(a & b);

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '1;
            act_cnt <= '0;
        end else if (en) begin
            y_q <= y;
            if (y != y_q && act_cnt != '1)
                act_cnt <= act_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_nand_gate.sv
// tb_nand_gate: directed self-checking bench for nand_gate (truth table, OR network, register, counter)
module tb_nand_gate;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Combinational-only cell: clock and reset parked low.
    logic a1, b1, y1, y1_q;
    logic [15:0] c1;
    nand_gate u_tt (.y(y1), .a(a1), .b(b1), .clk(1'b0), .rst(1'b0), .en(1'b0), .y_q(y1_q), .act_cnt(c1));

    // OR from three NANDs: two inverters feeding a third.
    logic ox, oz, nx, nz, o_or;
    logic nx_q, nz_q, or_q;
    logic [15:0] cx, cz, co;
    nand_gate u_inx (.y(nx), .a(ox), .b(ox), .clk(1'b0), .rst(1'b0), .en(1'b0), .y_q(nx_q), .act_cnt(cx));
    nand_gate u_inz (.y(nz), .a(oz), .b(oz), .clk(1'b0), .rst(1'b0), .en(1'b0), .y_q(nz_q), .act_cnt(cz));
    nand_gate u_or  (.y(o_or), .a(nx), .b(nz), .clk(1'b0), .rst(1'b0), .en(1'b0), .y_q(or_q), .act_cnt(co));

    // Main 4-bit instance.
    logic [3:0] a4, b4, y4, y4_q;
    logic rst, en;
    logic [15:0] cnt4;
    nand_gate #(.WIDTH(4), .CNT_W(16)) dut (
        .y(y4), .a(a4), .b(b4), .clk(clk), .rst(rst), .en(en), .y_q(y4_q), .act_cnt(cnt4)
    );

    // Narrow counter instance for saturation.
    logic as_, bs, ys, ys_q, rsts, ens;
    logic [1:0] cnts;
    nand_gate #(.WIDTH(1), .CNT_W(2)) u_sat (
        .y(ys), .a(as_), .b(bs), .clk(clk), .rst(rsts), .en(ens), .y_q(ys_q), .act_cnt(cnts)
    );

    logic [3:0] tt_y [4] = '{1, 1, 1, 0};
    logic [3:0] or_y [4] = '{0, 1, 1, 1};
    logic [3:0] reg_b [3] = '{4'hF, 4'h0, 4'h0};
    logic [3:0] reg_q [3] = '{4'h0, 4'hF, 4'hF};
    int         reg_c [3] = '{1, 2, 2};
    logic [3:0] hold_a [5] = '{4'h3, 4'hF, 4'hA, 4'hC, 4'hF};
    logic [3:0] hold_b [5] = '{4'h5, 4'h0, 4'hA, 4'h6, 4'hF};
    logic [3:0] hold_y [5] = '{4'hE, 4'hF, 4'h5, 4'hB, 4'h0};
    logic       sat_a  [6] = '{1, 0, 1, 0, 1, 0};
    logic       sat_q  [6] = '{0, 1, 0, 1, 0, 1};
    int         sat_c  [6] = '{1, 2, 3, 3, 3, 3};

    initial begin
        a1 = 0; b1 = 0; ox = 0; oz = 0;
        a4 = 4'hF; b4 = 4'hF; rst = 1; en = 1;
        as_ = 0; bs = 1; rsts = 1; ens = 0;

        for (int i = 0; i < 4; i++) begin
            {a1, b1} = 2'(i);
            #1 check($sformatf("tt_%0d", i), 32'(y1), 32'(tt_y[i]));
        end
        for (int i = 0; i < 4; i++) begin
            {ox, oz} = 2'(i);
            #1 check($sformatf("or_%0d", i), 32'(o_or), 32'(or_y[i]));
        end

        @(negedge clk);
        tick();
        tick();
        check("rst_yq", 32'(y4_q), 32'hF);
        check("rst_cnt", 32'(cnt4), 32'h0);
        check("rst_y", 32'(y4), 32'h0);

        rst = 0;
        rsts = 0;
        for (int i = 0; i < 3; i++) begin
            b4 = reg_b[i];
            tick();
            check($sformatf("reg_yq_%0d", i), 32'(y4_q), 32'(reg_q[i]));
            check($sformatf("reg_cnt_%0d", i), 32'(cnt4), 32'(reg_c[i]));
        end

        en = 0;
        for (int i = 0; i < 5; i++) begin
            a4 = hold_a[i];
            b4 = hold_b[i];
            #1 check($sformatf("hold_y_%0d", i), 32'(y4), 32'(hold_y[i]));
            tick();
            check($sformatf("hold_yq_%0d", i), 32'(y4_q), 32'hF);
            check($sformatf("hold_cnt_%0d", i), 32'(cnt4), 32'h2);
        end

        // Reset wins over an enabled capture that would have changed y_q.
        en = 1; a4 = 4'hF; b4 = 4'hF; rst = 1;
        tick();
        check("midrst_yq", 32'(y4_q), 32'hF);
        check("midrst_cnt", 32'(cnt4), 32'h0);
        rst = 0;
        tick();
        check("postrst_yq", 32'(y4_q), 32'h0);
        check("postrst_cnt", 32'(cnt4), 32'h1);

        ens = 1;
        for (int i = 0; i < 6; i++) begin
            as_ = sat_a[i];
            tick();
            check($sformatf("sat_yq_%0d", i), 32'(ys_q), 32'(sat_q[i]));
            check($sformatf("sat_cnt_%0d", i), 32'(cnts), 32'(sat_c[i]));
        end
        as_ = 1;
        rsts = 1;
        tick();
        check("sat_rst_cnt", 32'(cnts), 32'h0);
        check("sat_rst_yq", 32'(ys_q), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
